adrv9001_rx_align_ctrl: RTL and testbench

ADRV9001_RX_ALIGN_CTRL -- requirements
Module: adrv9001_rx_align_ctrl

---
 rtl/adrv9001_pkg.sv | 24 ++
 rtl/adrv9001_strb_phase_detect.sv | 35 +++
 rtl/adrv9001_rx_align_ctrl.sv | 163 ++++++++++++++++
 tb/tb_adrv9001_rx_align_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_pkg.sv
// Shared definitions for the ADRV9001 RX strobe alignment logic.
//   align_state_t : controller FSM encoding (also driven out on the state port)
//   PAT_1_15/PAT_8_8 : strobe patterns for the two strobe formats
//   CNT_W/ERR_W   : lock/miss counter width and error counter width
package adrv9001_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } align_state_t;

   localparam logic [15:0] PAT_1_15 = 16'h8000;
   localparam logic [15:0] PAT_8_8  = 16'hFF00;

   localparam int CNT_W = 8;
   localparam int ERR_W = 16;

   function automatic logic [15:0] strb_pattern(input logic mode);
      return mode ? PAT_8_8 : PAT_1_15;
   endfunction

endpackage

// File: rtl/adrv9001_strb_phase_detect.sv
// Combinational strobe phase search.
//   prev  : previous valid strobe word (older half of the window)
//   cur   : current strobe word
//   mode  : 0 = 1-on/15-off, 1 = 8-on/8-off
//   p     : lowest bit offset at which the pattern appears in {prev, cur}
//   match : pattern found at some offset 0..15
module adrv9001_strb_phase_detect
   import adrv9001_pkg::*;
(
   input  logic [15:0] prev,
   input  logic [15:0] cur,
   input  logic        mode,
   output logic [3:0]  p,
   output logic        match
);

   logic [31:0] w;
   logic [15:0] pat;

   assign w   = {prev, cur};
   assign pat = strb_pattern(mode);

   // Scan from high offset down so the lowest matching offset wins.
   always_comb begin
      p     = '0;
      match = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (w[31-i -: 16] == pat) begin
            p     = 4'(i);
            match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adrv9001_rx_align_ctrl.sv
// ADRV9001 RX strobe alignment controller.
// Searches the strobe stream for the framing pattern, verifies it over
// LOCK_CNT consecutive words, then holds lock until UNLOCK_CNT consecutive
// misses.
//   clk, rstn  : clock, asynchronous active-low reset
//   enable     : 1 = run alignment, 0 = force IDLE (phase held)
//   mode       : strobe format select
//   strb_in    : strobe word, MSB first in time; valid_in qualifies it
//   clr        : pulse, clears err_cnt and lock_lost
//   phase      : bit offset for the aligner datapath (updates only on lock)
//   locked     : 1 while LOCKED
//   lock_lost  : sticky, set on every LOCKED->SEARCH exit
//   err_cnt    : saturating count of bad words seen while LOCKED
//   state      : FSM state
module adrv9001_rx_align_ctrl
   import adrv9001_pkg::*;
#(
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_CNT = 4
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic        mode,
   input  logic [15:0] strb_in,
   input  logic        valid_in,
   input  logic        clr,
   output logic [3:0]  phase,
   output logic        locked,
   output logic        lock_lost,
   output logic [15:0] err_cnt,
   output logic [1:0]  state
);

   localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_CNT);

   align_state_t     st;
   logic [15:0]      prev;
   logic             prev_ok;
   logic [CNT_W-1:0] mcnt;
   logic [CNT_W-1:0] miss;
   logic [3:0]       cand;
   logic [3:0]       p;
   logic             match;
   logic             eval;
   logic             hit_lock;
   logic             err_inc;
   logic             lost_set;

   adrv9001_strb_phase_detect u_det (
      .prev  (prev),
      .cur   (strb_in),
      .mode  (mode),
      .p     (p),
      .match (match)
   );

   assign state    = st;
   assign eval     = valid_in & prev_ok & enable;
   assign hit_lock = match & (p == phase);

   always_comb begin
      err_inc  = 1'b0;
      lost_set = 1'b0;
      if (st == ST_LOCKED && eval && !hit_lock) begin
         err_inc  = 1'b1;
         lost_set = (miss == UNLOCK_N - 1'b1);
      end
   end

   // The window needs one earlier word; the first valid word after IDLE only primes prev.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prev    <= '0;
         prev_ok <= 1'b0;
      end else begin
         if (valid_in) prev <= strb_in;
         if (!enable || st == ST_IDLE) prev_ok <= 1'b0;
         else if (valid_in)            prev_ok <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st     <= ST_IDLE;
         phase  <= '0;
         locked <= 1'b0;
         cand   <= '0;
         mcnt   <= '0;
         miss   <= '0;
      end else if (!enable) begin
         st     <= ST_IDLE;
         locked <= 1'b0;
         mcnt   <= '0;
         miss   <= '0;
      end else begin
         case (st)
            ST_IDLE: st <= ST_SEARCH;
            ST_SEARCH: begin
               if (eval && match) begin
                  cand <= p;
                  if (LOCK_N == 8'd1) begin
                     st     <= ST_LOCKED;
                     phase  <= p;
                     locked <= 1'b1;
                     miss   <= '0;
                  end else begin
                     st   <= ST_VERIFY;
                     mcnt <= 8'd1;
                  end
               end
            end
            ST_VERIFY: begin
               if (eval) begin
                  if (match && p == cand) begin
                     if (mcnt + 1'b1 == LOCK_N) begin
                        st     <= ST_LOCKED;
                        phase  <= cand;
                        locked <= 1'b1;
                        mcnt   <= '0;
                        miss   <= '0;
                     end else begin
                        mcnt <= mcnt + 1'b1;
                     end
                  end else begin
                     st   <= ST_SEARCH;
                     mcnt <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (eval) begin
                  if (hit_lock) begin
                     miss <= '0;
                  end else if (lost_set) begin
                     st     <= ST_SEARCH;
                     locked <= 1'b0;
                     miss   <= '0;
                  end else begin
                     miss <= miss + 1'b1;
                  end
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   // clr wins over an increment; a lock-loss event wins over clr.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_cnt   <= '0;
         lock_lost <= 1'b0;
      end else begin
         if (clr)                             err_cnt <= '0;
         else if (err_inc && err_cnt != '1)   err_cnt <= err_cnt + 1'b1;
         if (lost_set)  lock_lost <= 1'b1;
         else if (clr)  lock_lost <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adrv9001_rx_align_ctrl.sv
// Directed bench for adrv9001_rx_align_ctrl. Inputs change on the falling
// edge, outputs are sampled on the following falling edge.
module tb_adrv9001_rx_align_ctrl;

   logic        clk = 1'b0;
   logic        rstn, enable, mode, valid_in, clr;
   logic [15:0] strb_in;
   logic [3:0]  phase;
   logic        locked, lock_lost;
   logic [15:0] err_cnt;
   logic [1:0]  state;

   logic        s_enable, s_mode, s_valid, s_clr;
   logic [15:0] s_strb;
   logic [3:0]  s_phase;
   logic        s_locked, s_lock_lost;
   logic [15:0] s_err;
   logic [1:0]  s_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adrv9001_rx_align_ctrl dut (
      .clk(clk), .rstn(rstn), .enable(enable), .mode(mode), .strb_in(strb_in),
      .valid_in(valid_in), .clr(clr), .phase(phase), .locked(locked),
      .lock_lost(lock_lost), .err_cnt(err_cnt), .state(state)
   );

   // Instant lock and a long miss tolerance, so the error counter can be run to saturation.
   adrv9001_rx_align_ctrl #(.LOCK_CNT(1), .UNLOCK_CNT(255)) u_sat (
      .clk(clk), .rstn(rstn), .enable(s_enable), .mode(s_mode), .strb_in(s_strb),
      .valid_in(s_valid), .clr(s_clr), .phase(s_phase), .locked(s_locked),
      .lock_lost(s_lock_lost), .err_cnt(s_err), .state(s_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic word(input logic [15:0] w);
      strb_in  = w;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      strb_in  = 16'hFFFF;
      repeat (n) @(negedge clk);
   endtask

   task automatic sword(input logic [15:0] w);
      s_strb  = w;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; enable = 1'b0; mode = 1'b0; valid_in = 1'b0; clr = 1'b0; strb_in = '0;
      s_enable = 1'b0; s_mode = 1'b0; s_valid = 1'b0; s_clr = 1'b0; s_strb = '0;
      repeat (2) @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_phase", phase, 0);
      chk("rst_locked", locked, 0);
      chk("rst_lock_lost", lock_lost, 0);
      chk("rst_err", err_cnt, 0);
      rstn = 1'b1;
      @(negedge clk);

      // 1-on/15-off lock at phase 7: 1 priming word + 8 matches
      enable = 1'b1;
      idle(1);
      chk("search_entry", state, 1);
      repeat (8) word(16'h0100);
      chk("m0_verify_8", state, 2);
      chk("m0_unlocked_8", locked, 0);
      word(16'h0100);
      chk("m0_locked_9", locked, 1);
      chk("m0_phase", phase, 7);
      chk("m0_state_lck", state, 3);
      repeat (11) word(16'h0100);
      chk("m0_locked_20", locked, 1);
      chk("m0_err_20", err_cnt, 0);

      // 3 bad, 1 good, 3 bad: each word is judged against the previous one
      word(16'h8000); word(16'h8000); word(16'h0100);
      word(16'h0100);
      word(16'h8000); word(16'h8000); word(16'h0100);
      chk("hold_locked", locked, 1);
      chk("hold_err6", err_cnt, 6);
      word(16'h0100);
      word(16'h8000); word(16'h8000); word(16'h8000);
      chk("miss3_locked", locked, 1);
      chk("miss3_err", err_cnt, 9);
      word(16'h8000);
      chk("unlock_state", state, 1);
      chk("unlock_locked", locked, 0);
      chk("unlock_lost", lock_lost, 1);
      chk("unlock_err", err_cnt, 10);
      chk("unlock_phase", phase, 7);
      clr = 1'b1; idle(1); clr = 1'b0;
      chk("clr_lost", lock_lost, 0);
      chk("clr_err", err_cnt, 0);

      // 8-on/8-off at phase 4, corrupted word in VERIFY restarts the count
      mode = 1'b1;
      word(16'h0FF0);
      chk("m1_nomatch", state, 1);
      repeat (4) word(16'h0FF0);
      chk("m1_verify", state, 2);
      word(16'hFFFF);
      chk("m1_corrupt", state, 1);
      word(16'h0FF0);
      chk("m1_still_search", state, 1);
      repeat (7) word(16'h0FF0);
      chk("m1_verify7", state, 2);
      chk("m1_unlocked7", locked, 0);
      word(16'h0FF0);
      chk("m1_locked", locked, 1);
      chk("m1_phase", phase, 4);

      // enable low from LOCKED, then again from VERIFY: phase must hold
      enable = 1'b0; idle(1);
      chk("dis_state", state, 0);
      chk("dis_locked", locked, 0);
      mode = 1'b0; enable = 1'b1; idle(1);
      repeat (4) word(16'h0100);
      chk("ver_state", state, 2);
      enable = 1'b0; idle(1);
      chk("dis_ver_state", state, 0);
      chk("dis_ver_phase", phase, 4);

      // valid_in toggling: only valid words advance lock
      enable = 1'b1; idle(1);
      for (int i = 0; i < 8; i++) begin
         word(16'h0100);
         idle(1);
      end
      chk("tog_verify", state, 2);
      chk("tog_unlocked", locked, 0);
      idle(3);
      chk("tog_idle_hold", state, 2);
      word(16'h0100);
      chk("tog_locked", locked, 1);
      chk("tog_phase", phase, 7);

      // asynchronous reset mid-LOCKED
      #2 rstn = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_state", state, 0);
      chk("arst_phase", phase, 0);
      @(negedge clk);
      rstn = 1'b1;

      // error counter saturation on the LOCK_CNT=1 instance
      s_enable = 1'b1;
      @(negedge clk);
      sword(16'h0100);
      sword(16'h0100);
      chk("sat_locked", s_locked, 1);
      chk("sat_phase", s_phase, 7);
      // each block: 254 bad words then one good word
      for (int b = 0; b < 258; b++) begin
         for (int k = 0; k < 253; k++) sword(16'h8000);
         sword(16'h0100);
         sword(16'h0100);
      end
      chk("sat_pre", s_err, 16'hFFFC);
      chk("sat_pre_lck", s_locked, 1);
      repeat (3) sword(16'h8000);
      chk("sat_full", s_err, 16'hFFFF);
      repeat (2) sword(16'h8000);
      chk("sat_hold", s_err, 16'hFFFF);
      s_clr = 1'b1;
      sword(16'h8000);
      s_clr = 1'b0;
      chk("sat_clr_err", s_err, 0);
      chk("sat_clr_lck", s_locked, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
